rx: RTL and testbench

RX -- requirements
Module: rx

---
 rtl/rx.sv | 171 +++++++++++++++++
 tb/tb_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx.sv
// -----------------------------------------------------------------------------
// rx : serial link receiver with a small receive FIFO.
//
// Frame on serial_in: one start bit (1), then W data bits LSB first, one bit
// per clock, with no stop bit. Each completed word is pushed into a DEPTH-entry
// FIFO. The consumer pops the FIFO with ack.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   serial_in     link line from the upstream transmitter (low when idle)
//   ack           pop request, ignored while the FIFO is empty
//   parallel_out  head-of-FIFO flit, zero when the FIFO is empty
//   data_valid    FIFO holds at least one flit
//   channel_busy  FIFO full (back-pressure to the transmitter)
//   rx_active     a frame body is being shifted in
//   overflow      sticky: a completed frame was dropped on a full FIFO
//
// FSM states
//   state | meaning
//   IDLE  | waiting for a start bit on serial_in
//   RECV  | sampling data bit [bit_cnt] every clock
// -----------------------------------------------------------------------------
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 2
`endif

module rx #(
  parameter int routerid = -1,
  parameter     port     = "unknown",
  parameter int DEPTH    = 2,
  localparam int W       = `PAYLOAD_SIZE + `ADDR_BITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         ack,
  output logic [W-1:0] parallel_out,
  output logic         data_valid,
  output logic         channel_busy,
  output logic         rx_active,
  output logic         overflow
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  // routerid and port only label an instance for debug; they shape nothing.
  if (routerid < -1) begin : g_routerid_label
  end
  if ($bits(port) == 0) begin : g_port_label
  end

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [W-1:0]       shift_q, shift_d;
  logic               word_done;

  logic [W-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [OCC_W-1:0]   count_q;
  logic               overflow_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic               do_pop;
  logic               do_push;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (serial_in) begin
          state_d   = RECV;
          bit_cnt_d = '0;
        end
      end
      RECV: begin
        // shift_d doubles as the word handed to the FIFO on the last bit, so
        // the final bit does not need an extra cycle to land in shift_q.
        shift_d[bit_cnt_q] = serial_in;
        if (bit_cnt_q == CNT_W'(W - 1)) begin
          word_done = 1'b1;
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (count_q == OCC_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign do_pop     = ack && !fifo_empty;
  // A pop on the same edge frees the head slot, so a full FIFO still accepts.
  assign do_push    = word_done && (!fifo_full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_pop) begin
        head_q <= ptr_inc(head_q);
      end
      if (do_push) begin
        mem[tail_q] <= shift_d;
        tail_q      <= ptr_inc(tail_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (word_done && !do_push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign data_valid   = !fifo_empty;
  assign channel_busy = fifo_full;
  assign parallel_out = fifo_empty ? '0 : mem[head_q];
  assign rx_active    = (state_q == RECV);
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_rx.sv
// -----------------------------------------------------------------------------
// tb_rx : scoreboard bench for rx (W=10, DEPTH=2).
// The driver serialises words onto the line and tells the reference model when
// the last bit of a frame is on the line; the model keeps the expected FIFO
// contents as a queue. A monitor on the falling edge compares every output.
// -----------------------------------------------------------------------------
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 2
`endif

module tb_rx;
  localparam int W     = `PAYLOAD_SIZE + `ADDR_BITS;
  localparam int DEPTH = 2;

  logic         clk;
  logic         reset;
  logic         serial_in;
  logic         ack;
  logic [W-1:0] parallel_out;
  logic         data_valid;
  logic         channel_busy;
  logic         rx_active;
  logic         overflow;

  rx #(.routerid(3), .port("north"), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .ack          (ack),
    .parallel_out (parallel_out),
    .data_valid   (data_valid),
    .channel_busy (channel_busy),
    .rx_active    (rx_active),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // driver -> model side channel
  logic         drv_body;   // a data bit is on the line this cycle
  logic         drv_last;   // that data bit is the last one of its frame
  logic [W-1:0] drv_word;

  // reference model state
  logic [W-1:0] exp_q[$];
  logic         exp_ovf;
  int           n_popped;
  logic         rand_ack_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference FIFO: pop when acked and non-empty; a finishing frame is stored
  // unless the FIFO was full and nothing was popped, in which case it is lost.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      bit was_full;
      bit pop;
      was_full = (exp_q.size() == DEPTH);
      pop      = ack && (exp_q.size() > 0);
      if (pop) void'(exp_q.pop_front());
      if (drv_last) begin
        if (was_full && !pop) exp_ovf = 1'b1;
        else exp_q.push_back(drv_word);
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    chk("data_valid", 32'(data_valid), 32'(exp_q.size() != 0));
    chk("channel_busy", 32'(channel_busy), 32'(exp_q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("rx_active", 32'(rx_active), 32'(drv_body));
    chk("parallel_out", 32'(parallel_out), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    if (data_valid && ack) n_popped++;
  end

  always @(posedge clk) begin
    #1;
    if (rand_ack_en) ack = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] word, input bit ack_last);
    drv_word  = word;
    serial_in = 1'b1;
    drv_body  = 1'b0;
    drv_last  = 1'b0;
    tick();
    for (int i = 0; i < W; i++) begin
      serial_in = word[i];
      drv_body  = 1'b1;
      drv_last  = (i == W - 1);
      if (i == W - 1 && ack_last) ack = 1'b1;
      tick();
    end
    serial_in = 1'b0;
    drv_body  = 1'b0;
    drv_last  = 1'b0;
    if (ack_last) ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pop_n(input int n);
    ack = 1'b1;
    repeat (n) tick();
    ack = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    serial_in = 1'b0;
    drv_body  = 1'b0;
    drv_last  = 1'b0;
    ack       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    logic [W-1:0] w;
    int           k;
    reset       = 1'b1;
    serial_in   = 1'b0;
    ack         = 1'b0;
    drv_body    = 1'b0;
    drv_last    = 1'b0;
    drv_word    = '0;
    rand_ack_en = 1'b0;
    n_popped    = 0;
    idle(3);
    reset = 1'b0;
    tick();

    // single frame, then pop it
    send_frame(10'h2A5, 1'b0);
    idle(3);
    pop_n(1);
    idle(2);

    // two back-to-back frames fill the FIFO, a third is dropped
    do_reset();
    send_frame(10'h001, 1'b0);
    send_frame(10'h3FF, 1'b0);
    idle(2);
    send_frame(10'h123, 1'b0);
    idle(2);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    pop_n(3);
    idle(2);

    // full FIFO, pop on the same edge as the third frame's last bit
    do_reset();
    send_frame(10'h001, 1'b0);
    send_frame(10'h3FF, 1'b0);
    send_frame(10'h2C7, 1'b1);
    chk("busy_after_swap", 32'(channel_busy), 32'd1);
    idle(1);
    pop_n(2);
    idle(2);

    // reset mid-frame with a stored word, then a clean frame
    send_frame(10'h0AB, 1'b0);
    drv_word  = 10'h155;
    serial_in = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      serial_in = drv_word[i];
      drv_body  = 1'b1;
      tick();
    end
    do_reset();
    chk("reset_empty", 32'(data_valid), 32'd0);
    send_frame(10'h0F0, 1'b0);
    idle(2);
    pop_n(1);
    idle(2);

    // random end-to-end: transmitter honours channel_busy, consumer acks randomly
    do_reset();
    n_popped    = 0;
    rand_ack_en = 1'b1;
    for (int f = 0; f < 20; f++) begin
      k = 0;
      while (channel_busy && k < 200) begin
        tick();
        k++;
      end
      if (channel_busy) chk("busy_timeout", 32'd1, 32'd0);
      w = W'($urandom);
      send_frame(w, 1'b0);
      idle($urandom_range(0, 3));
    end
    rand_ack_en = 1'b0;
    #1;
    ack = 1'b1;
    idle(2 * DEPTH + 2);
    ack = 1'b0;
    tick();
    chk("random_popped", 32'(n_popped), 32'd20);
    chk("random_overflow", 32'(overflow), 32'd0);
    chk("random_drained", 32'(data_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
